// File: rtl/control_fsm_pkg.sv
// Shared state/opcode encodings and ALU operation codes for the instruction sequencer.
package StateDefs;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        S_NOOP   = 4'd0,
        S_STORE  = 4'd1,
        S_LOAD_A = 4'd2,
        S_ADD    = 4'd3,
        S_SUB    = 4'd4,
        S_HALT   = 4'd5,
        S_LOAD_B = 4'd6,
        S_INIT   = 4'd7,
        S_FETCH  = 4'd8,
        S_DECODE = 4'd9
    } state_e;

    typedef enum logic [OP_W-1:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } inst_e;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch/decode/execute control with Moore
// outputs decoded from the registered state, plus a retired-instruction counter.
module control_fsm
    import StateDefs::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [1:0]  ALU_s,
    output logic [3:0]  CurState,
    output logic        Halted,
    output logic [15:0] RetireCnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [OP_W-1:0]  op;

    assign op = IR[15:12];

    // State register; reset wins over every transition
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   if (Run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if      (op == OP_NOOP)  state_d = S_NOOP;
                else if (op == OP_STORE) state_d = S_STORE;
                else if (op == OP_LOAD)  state_d = S_LOAD_A;
                else if (op == OP_ADD)   state_d = S_ADD;
                else if (op == OP_SUB)   state_d = S_SUB;
                else if (op == OP_HALT)  state_d = S_HALT;
                else                     state_d = S_NOOP;
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    // Moore output decode; anything a state does not drive stays 0
    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = 8'd0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s      = ALU_PASS;
        Halted     = 1'b0;
        case (state_q)
            S_INIT:  PC_clr = 1'b1;
            S_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            S_STORE: begin
                D_addr     = IR[7:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
            end
            // Load_B repeats Load_A's address to cover the memory read latency
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_addr = IR[3:0];
                RF_W_en   = (state_q == S_LOAD_B);
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

    // Retire counter: bumps when an execute state hands back to Fetch
    always_comb begin
        retire_d = retire_q;
        if (state_d == S_FETCH &&
            (state_q == S_NOOP || state_q == S_STORE || state_q == S_LOAD_B ||
             state_q == S_ADD  || state_q == S_SUB)) begin
            retire_d = retire_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign CurState  = state_q;
    assign RetireCnt = retire_q;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: vector table plus hand-written halt and
// mid-instruction reset sequences, checked through an expected-value queue.
module tb_control_fsm;

    logic        Clk = 1'b0;
    logic        Reset, Run;
    logic [15:0] IR;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, Halted;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, CurState;
    logic [1:0]  ALU_s;
    logic [15:0] RetireCnt;

    control_fsm dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .IR(IR),
        .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
        .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .ALU_s(ALU_s), .CurState(CurState), .Halted(Halted),
        .RetireCnt(RetireCnt)
    );

    always #5 Clk = ~Clk;

    // Expected encodings written out independently of the design package
    localparam logic [3:0] ST_NOOP = 4'd0, ST_STORE = 4'd1, ST_LDA = 4'd2, ST_ADD = 4'd3,
                           ST_SUB = 4'd4, ST_HALT = 4'd5, ST_LDB = 4'd6, ST_INIT = 4'd7,
                           ST_FETCH = 4'd8, ST_DEC = 4'd9;
    // flag order: {pc_clr, pc_up, ir_ld, d_wr, rf_s, w_en, halted}
    localparam logic [6:0] F_NONE = 7'b0000000, F_CLR = 7'b1000000, F_FET = 7'b0110000,
                           F_DWR = 7'b0001000, F_RFS = 7'b0000100, F_WEN = 7'b0000010,
                           F_HLT = 7'b0000001;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  flags;
        logic [1:0]  alu;
        logic [7:0]  d_addr;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  wa;
        logic [15:0] rc;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        run;
        logic [15:0] ir;
        obs_t        exp;
    } vec_t;

    vec_t tbl[$];
    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic obs_t o(input logic [3:0] st, input logic [6:0] fl, input logic [1:0] alu,
                               input logic [7:0] da, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] wa, input logic [15:0] rc);
        obs_t r;
        r.st = st; r.flags = fl; r.alu = alu; r.d_addr = da;
        r.ra = ra; r.rb = rb; r.wa = wa; r.rc = rc;
        return r;
    endfunction

    function automatic obs_t idle(input logic [3:0] st, input logic [6:0] fl, input logic [15:0] rc);
        return o(st, fl, 2'b00, 8'h00, 4'h0, 4'h0, 4'h0, rc);
    endfunction

    task automatic add(input logic rst, input logic run, input logic [15:0] ir, input obs_t e);
        vec_t v;
        v.rst = rst; v.run = run; v.ir = ir; v.exp = e;
        tbl.push_back(v);
    endtask

    function automatic obs_t sample();
        obs_t r;
        r.st = CurState;
        r.flags = {PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, Halted};
        r.alu = ALU_s; r.d_addr = D_addr;
        r.ra = RF_Ra_addr; r.rb = RF_Rb_addr; r.wa = RF_W_addr; r.rc = RetireCnt;
        return r;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge
    task automatic step(input string name, input logic rst, input logic run,
                        input logic [15:0] ir, input obs_t e);
        obs_t got, want;
        Reset = rst; Run = run; IR = ir;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
        got  = sample();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got st=%0d fl=%b alu=%b da=%h ra=%h rb=%h wa=%h rc=%h, want st=%0d fl=%b alu=%b da=%h ra=%h rb=%h wa=%h rc=%h",
                     name, got.st, got.flags, got.alu, got.d_addr, got.ra, got.rb, got.wa, got.rc,
                     want.st, want.flags, want.alu, want.d_addr, want.ra, want.rb, want.wa, want.rc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Run = 1'b0; IR = 16'h0000;

        // Reset, idle in Init, then a stream of add/load/store/sub/noop/halt
        add(1, 0, 16'hFFFF, idle(ST_INIT, F_CLR, 16'd0));
        for (int i = 0; i < 5; i++) add(0, 0, 16'h5000, idle(ST_INIT, F_CLR, 16'd0));
        add(0, 1, 16'hFFFF, idle(ST_FETCH, F_FET, 16'd0));
        add(0, 1, 16'hABCD, idle(ST_DEC, F_NONE, 16'd0));
        add(0, 0, 16'h3125, o(ST_ADD, F_WEN, 2'b01, 8'h00, 4'h1, 4'h2, 4'h5, 16'd0));
        add(0, 0, 16'h3125, idle(ST_FETCH, F_FET, 16'd1));
        add(0, 0, 16'h5555, idle(ST_DEC, F_NONE, 16'd1));
        add(0, 0, 16'h2AB7, o(ST_LDA, F_RFS, 2'b00, 8'hAB, 4'h0, 4'h0, 4'h7, 16'd1));
        add(0, 0, 16'h2AB7, o(ST_LDB, F_RFS | F_WEN, 2'b00, 8'hAB, 4'h0, 4'h0, 4'h7, 16'd1));
        add(0, 0, 16'h2AB7, idle(ST_FETCH, F_FET, 16'd2));
        add(0, 0, 16'h0000, idle(ST_DEC, F_NONE, 16'd2));
        add(0, 0, 16'h1C42, o(ST_STORE, F_DWR, 2'b00, 8'h42, 4'hC, 4'h0, 4'h0, 16'd2));
        add(0, 0, 16'h1C42, idle(ST_FETCH, F_FET, 16'd3));
        add(0, 0, 16'h1C42, idle(ST_DEC, F_NONE, 16'd3));
        add(0, 0, 16'h4FE1, o(ST_SUB, F_WEN, 2'b10, 8'h00, 4'hF, 4'hE, 4'h1, 16'd3));
        add(0, 0, 16'h4FE1, idle(ST_FETCH, F_FET, 16'd4));
        add(0, 0, 16'h3333, idle(ST_DEC, F_NONE, 16'd4));
        add(0, 0, 16'h9000, idle(ST_NOOP, F_NONE, 16'd4));
        add(0, 0, 16'h9000, idle(ST_FETCH, F_FET, 16'd5));
        add(0, 0, 16'h2222, idle(ST_DEC, F_NONE, 16'd5));
        add(0, 1, 16'hF123, idle(ST_NOOP, F_NONE, 16'd5));
        add(0, 0, 16'hF123, idle(ST_FETCH, F_FET, 16'd6));
        add(0, 0, 16'h1111, idle(ST_DEC, F_NONE, 16'd6));
        add(0, 0, 16'h5000, idle(ST_HALT, F_HLT, 16'd6));

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].run, tbl[i].ir, tbl[i].exp);
        end

        // Halt ignores Run and IR for 20 cycles
        for (int i = 0; i < 20; i++) begin
            step("halt_hold", 0, 1'($urandom_range(0, 1)), 16'($urandom),
                 idle(ST_HALT, F_HLT, 16'd6));
        end

        // Reset leaves Halt and clears the counter
        step("halt_reset", 1, 1, 16'h5000, idle(ST_INIT, F_CLR, 16'd0));

        // Reset in Load_A: no write-enable pulse, counter stays 0
        step("lda_fetch", 0, 1, 16'h0000, idle(ST_FETCH, F_FET, 16'd0));
        step("lda_dec",   0, 0, 16'h0000, idle(ST_DEC, F_NONE, 16'd0));
        step("lda_exec",  0, 0, 16'h2AB7, o(ST_LDA, F_RFS, 2'b00, 8'hAB, 4'h0, 4'h0, 4'h7, 16'd0));
        step("lda_reset", 1, 0, 16'h2AB7, idle(ST_INIT, F_CLR, 16'd0));
        step("lda_after", 0, 0, 16'h2AB7, idle(ST_INIT, F_CLR, 16'd0));

        // Reset in Store: D_wr must drop the next cycle
        step("st_fetch", 0, 1, 16'h1C42, idle(ST_FETCH, F_FET, 16'd0));
        step("st_dec",   0, 0, 16'h1C42, idle(ST_DEC, F_NONE, 16'd0));
        step("st_exec",  0, 0, 16'h1C42, o(ST_STORE, F_DWR, 2'b00, 8'h42, 4'hC, 4'h0, 4'h0, 16'd0));
        step("st_reset", 1, 1, 16'h1C42, idle(ST_INIT, F_CLR, 16'd0));

        // Reset in Load_B: RF_W_en must drop, load does not retire
        step("ldb_fetch", 0, 1, 16'h2AB7, idle(ST_FETCH, F_FET, 16'd0));
        step("ldb_dec",   0, 0, 16'h2AB7, idle(ST_DEC, F_NONE, 16'd0));
        step("ldb_lda",   0, 0, 16'h2AB7, o(ST_LDA, F_RFS, 2'b00, 8'hAB, 4'h0, 4'h0, 4'h7, 16'd0));
        step("ldb_ldb",   0, 0, 16'h2AB7, o(ST_LDB, F_RFS | F_WEN, 2'b00, 8'hAB, 4'h0, 4'h0, 4'h7, 16'd0));
        step("ldb_reset", 1, 0, 16'h2AB7, idle(ST_INIT, F_CLR, 16'd0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset, with all state changing only on the rising edge of Clk.
REQ-002 Clk  input  1  system clock; all sequential logic SHALL use its rising edge.
REQ-003 Reset  input  1  synchronous active-high reset; it SHALL be sampled on the Clk rising edge.
REQ-004 Run  input  1  start request; it SHALL be sampled only in Init.
REQ-005 IR  input  16  instruction register contents, fields op[15:12], a[11:8], b[7:4], c[3:0].
REQ-006 PC_clr  output  1  clears the program counter.
REQ-007 PC_up  output  1  increments the program counter.
REQ-008 IR_ld  output  1  loads IR from instruction memory.
REQ-009 D_addr  output  8  data memory address.
REQ-010 D_wr  output  1  data memory write enable.
REQ-011 RF_s  output  1  register-file write-data select: 1 = memory data, 0 = ALU result.
REQ-012 RF_W_addr  output  4  register-file write address.
REQ-013 RF_W_en  output  1  register-file write enable.
REQ-014 RF_Ra_addr, RF_Rb_addr  output  4 each  register-file read addresses.
REQ-015 ALU_s  output  2  ALU operation: 00 pass, 01 add, 10 sub.
REQ-016 CurState  output  4  current State encoding, for debug.
REQ-017 Halted  output  1  high while in Halt.
REQ-018 RetireCnt  output  16  count of retired instructions.

Function
REQ-019 The states SHALL be Init, Fetch, Decode, Noop, Store, Load_A, Load_B, Add, Sub and Halt, using the shared State encoding.
REQ-020 Init SHALL assert PC_clr, stay in Init while Run=0, and go to Fetch when Run=1.
REQ-021 Fetch SHALL assert IR_ld and PC_up, then go to Decode.
REQ-022 Decode SHALL assert no outputs and branch on op: 0 to Noop, 1 to Store, 2 to Load_A, 3 to Add, 4 to Sub, 5 to Halt.
REQ-023 In Decode, op values 6-15 SHALL go to Noop (treated as no-op).
REQ-024 Noop SHALL assert no outputs, then go to Fetch.
REQ-025 Store SHALL drive D_addr=IR[7:0], RF_Ra_addr=IR[11:8] and D_wr=1, then go to Fetch.
REQ-026 Load_A SHALL drive D_addr=IR[11:4], RF_s=1 and RF_W_addr=IR[3:0] with RF_W_en=0, then go to Load_B.
REQ-027 Load_B SHALL drive the same values as Load_A plus RF_W_en=1 (one-cycle memory read latency), then go to Fetch.
REQ-028 Add SHALL drive RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, RF_s=0 and ALU_s=01, then go to Fetch.
REQ-029 Sub SHALL drive the same as Add except ALU_s=10.
REQ-030 Halt SHALL assert Halted, ignore Run and IR, and stay in Halt until Reset.
REQ-031 All control outputs SHALL be Moore outputs of the registered state; any output a state does not drive SHALL be 0.
REQ-032 Per-instruction latency in cycles SHALL be: Noop, Store, Add and Sub 3; Load 4; Halt 2 to enter Halt.
REQ-033 RetireCnt SHALL increment by 1 on each transition from Noop, Store, Load_B, Add or Sub into Fetch.
REQ-034 RetireCnt SHALL wrap from 0xFFFF to 0x0000.
REQ-035 Halt SHALL NOT increment RetireCnt.
REQ-036 IR SHALL be used only in Decode and the execute states; its value in Init and Fetch SHALL be ignored.

Reset
REQ-037 Reset SHALL take priority over every transition, including mid-instruction, and force Init on the next edge.
REQ-038 Reset SHALL clear RetireCnt to 0.
REQ-039 The cycle after Reset SHALL show CurState=Init, PC_clr=1 and every other output 0.
REQ-040 Reset asserted in Store or Load_B SHALL leave D_wr and RF_W_en at 0 in the following cycle.

Structure
REQ-041 The State enum (Noop=0, Store=1, Load_A=2, Add=3, Sub=4, Halt=5, Load_B, Init, Fetch, Decode) and the inst opcode enum SHALL live in the shared StateDefs package.
REQ-042 The ALU_s codes SHALL be defined as constants in the StateDefs package.
REQ-043 Decode SHALL compare op against the inst enum, never against literals.
REQ-044 The module SHALL be a single module with separate next-state, output-decode and counter processes; no sub-module is required.

Verification
REQ-045 Reset, then Run=0 for 5 cycles: the bench SHALL see Init held with PC_clr=1; after Run=1, Fetch next cycle with IR_ld=PC_up=1.
REQ-046 IR=0x3125 (add): the bench SHALL see Fetch, Decode, Add with Ra=1, Rb=2, W=5, ALU_s=01, RF_W_en=1, then Fetch, with RetireCnt 0 to 1.
REQ-047 IR=0x2AB7 (load): the bench SHALL see Load_A with D_addr=0xAB, RF_s=1, RF_W_en=0, then Load_B with RF_W_en=1 and W=7.
REQ-048 IR=0x1C42 (store): the bench SHALL see D_addr=0x42, RF_Ra_addr=0xC, D_wr=1 for exactly one cycle.
REQ-049 IR=0x9000, then IR=0x5000: the bench SHALL see the undefined opcode take the Noop path, then Halt with Halted=1 held for 20 cycles regardless of Run.
REQ-050 Reset asserted in Load_A: the bench SHALL see Init next cycle, no RF_W_en pulse, and RetireCnt=0.
